truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
Hardware response checker for small combinational blocks under test. A stimulus source applies input vectors to the block under test and forwards each (input vector, observed output) pair to this block over a valid/ready stream. The block compares each pair against a parameterised expected truth table, counts mismatches, and tracks coverage of all input combinations. It reports pass/fail once every combination has been seen or a sample limit is hit.

Parameters:
N_IN, 2, input vector width of the block under test (1..4)
EXP_TT, 4'b0110, expected output per input index; bit i = expected f for input value i; width 2**N_IN
MAX_SMP, 16, maximum samples accepted per run before forced completion (>= 2**N_IN)
ERR_CNT_W, 8, mismatch counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin or restart a run
smp_valid  in  1  sample present
smp_ready  out  1  checker accepts sample
smp_in  in  N_IN  input vector applied to the block under test
smp_out  in  1  observed output of the block under test
busy  out  1  high in RUN
done  out  1  high in DONE
pass  out  1  result, meaningful only when done=1
err_cnt  out  ERR_CNT_W  saturating mismatch count
cover_mask  out  2**N_IN  bit i set once input value i has been accepted
first_err_vld  out  1  at least one mismatch seen this run
first_err_idx  out  N_IN  smp_in of the first mismatch

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). rst_n=0 forces IDLE and clears all outputs and internal counters to 0, at any time including mid-run.
- States: IDLE -> RUN on start; RUN -> DONE on completion; DONE -> RUN on start. No other transitions.
- smp_ready = 1 only in RUN (combinational from state). A sample is accepted on a rising edge where smp_valid & smp_ready. Samples outside RUN are ignored.
- Entering RUN clears err_cnt, cover_mask, first_err_vld, first_err_idx, pass, and the sample counter.
- On accept: mismatch = smp_out != EXP_TT[smp_in]. err_cnt += mismatch, saturating at all-ones. cover_mask[smp_in] <= 1. The first mismatch latches first_err_idx and sets first_err_vld; later mismatches do not overwrite it. The sample counter increments.
- Completion, evaluated on the accepting edge: full coverage (including the current sample), or sample count reaching MAX_SMP. On that edge the state goes to DONE and pass <= (no mismatch including the current one) & full coverage. All updates land on the same edge, so done is visible the cycle after the final valid.
- If both completion conditions hold on the same edge, treat it as coverage completion; pass follows the rule above.
- start while in RUN is ignored. start and an accepted sample on the same edge in RUN: the sample is processed and start is ignored.
- In DONE, all result outputs hold until start or reset.
- Repeated samples of an already covered index are legal: they are counted and checked.

Optional Feature:
Macro TT_CHK_ERRMASK_EN. When defined, add output err_mask [2**N_IN-1:0]: a sticky per-index mismatch flag, set on a mismatched accept at index smp_in, cleared on entering RUN and on reset. When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package tt_chk_pkg holds the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the localparam N_COMB = 2**N_IN helper.
- Sub-module tt_cover_tracker: holds cover_mask and the full-coverage flag. Inputs are clear, accept strobe, and index. Outputs are the mask and a combinational "full if this index is added" flag used for same-edge completion.

Test Plan:
All scenarios use EXP_TT=4'b0110 and N_IN=2 unless stated otherwise.
- Reset: rst_n low -> busy=done=pass=0, err_cnt=0, cover_mask=0, smp_ready=0. Samples in IDLE have no effect.
- Exhaustive correct XOR: start, then (00,0),(01,1),(10,1),(11,0) back-to-back -> done=1 the cycle after the 4th sample, pass=1, err_cnt=0, cover_mask=4'b1111.
- Fault: same sequence with (11,1) and (01,0) -> err_cnt=2, first_err_idx=2'b01, first_err_vld=1, pass=0.
- Coverage limit: sixteen samples of (00,0) -> done after the 16th, cover_mask=4'b0001, pass=0, err_cnt=0.
- Reset mid-run after 2 samples -> all cleared, state IDLE. A new start then runs normally.
- Saturation and restart with ERR_CNT_W=2: six mismatches, err_cnt=3. start in RUN is ignored; start in DONE clears the counts and re-enters RUN (busy=1).

Source files
------------

// File: rtl/tt_chk_pkg.sv
// Shared types for the truth-table response checker.
// State encoding and the input-combination count helper.
package tt_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tt_state_e;

    // Number of distinct input combinations for an n-bit input vector.
    function automatic int tt_n_comb(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_cover_tracker.sv
// Coverage tracker: one sticky bit per accepted input index.
// Ports: clk, rst_n, clr, acc, idx -> mask, full_nxt.
module tt_cover_tracker #(
    parameter int N_IN = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               acc,
    input  logic [N_IN-1:0]    idx,
    output logic [2**N_IN-1:0] mask,
    output logic               full_nxt
);

    logic [2**N_IN-1:0] hit;

    always_comb begin
        hit      = '0;
        hit[idx] = 1'b1;
    end

    // Full coverage assuming the index on idx is also counted,
    // so completion can be decided on the accepting edge.
    assign full_nxt = &(mask | hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else if (clr) begin
            mask <= '0;
        end else if (acc) begin
            mask <= mask | hit;
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Checks (input, output) samples against an expected truth table.
// Ports: clk, rst_n, start, smp_valid/smp_ready/smp_in/smp_out,
// busy, done, pass, err_cnt, cover_mask, first_err_vld/_idx;
// err_mask only when TT_CHK_ERRMASK_EN is defined.
module truth_table_checker
    import tt_chk_pkg::*;
#(
    parameter int                 N_IN      = 2,
    parameter logic [2**N_IN-1:0] EXP_TT    = 4'b0110,
    parameter int                 MAX_SMP   = 16,
    parameter int                 ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 smp_valid,
    output logic                 smp_ready,
    input  logic [N_IN-1:0]      smp_in,
    input  logic                 smp_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [2**N_IN-1:0]   cover_mask,
`ifdef TT_CHK_ERRMASK_EN
    output logic [2**N_IN-1:0]   err_mask,
`endif
    output logic                 first_err_vld,
    output logic [N_IN-1:0]      first_err_idx
);

    localparam int N_COMB = tt_n_comb(N_IN);
    localparam int CNT_W  = $clog2(MAX_SMP + 1);

    tt_state_e        state_q;
    tt_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             acc;
    logic             mis;
    logic             enter;
    logic             full_nxt;
    logic             fin;

    assign smp_ready = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

    assign acc     = smp_valid & smp_ready;
    assign mis     = smp_out != EXP_TT[smp_in];
    assign enter   = start & (state_q != RUN);
    assign cnt_nxt = cnt_q + CNT_W'(1);
    assign fin     = acc & (full_nxt | (cnt_nxt == CNT_W'(MAX_SMP)));

    tt_cover_tracker #(
        .N_IN (N_IN)
    ) u_cover (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (enter),
        .acc      (acc),
        .idx      (smp_in),
        .mask     (cover_mask),
        .full_nxt (full_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (fin)   state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            pass          <= 1'b0;
        end else if (enter) begin
            cnt_q         <= '0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            pass          <= 1'b0;
        end else if (acc) begin
            cnt_q <= cnt_nxt;
            if (mis) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                end
                if (!first_err_vld) begin
                    first_err_vld <= 1'b1;
                    first_err_idx <= smp_in;
                end
            end
            // Coverage wins a tie with the sample limit; pass
            // still requires a clean run including this sample.
            if (fin) begin
                pass <= ~(first_err_vld | mis) & full_nxt;
            end
        end
    end

`ifdef TT_CHK_ERRMASK_EN
    logic [N_COMB-1:0] em_hit;

    always_comb begin
        em_hit         = '0;
        em_hit[smp_in] = mis;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mask <= '0;
        end else if (enter) begin
            err_mask <= '0;
        end else if (acc) begin
            err_mask <= err_mask | em_hit;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker (N_IN=2, XOR table).
// A second instance with a 2-bit error counter checks saturation.
module tb_truth_table_checker;

    localparam int TT  = 4'b0110;
    localparam int MAX = 16;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       smp_valid;
    logic [1:0] smp_in;
    logic       smp_out;

    logic       rdy, busy, done, pass, fev;
    logic [7:0] ecnt;
    logic [3:0] cmask;
    logic [1:0] fidx;
    logic       rdy2, busy2, done2, pass2, fev2;
    logic [1:0] ecnt2;
    logic [3:0] cmask2;
    logic [1:0] fidx2;
`ifdef TT_CHK_ERRMASK_EN
    logic [3:0] em, em2;
`endif

    truth_table_checker #(
        .N_IN(2), .EXP_TT(4'b0110), .MAX_SMP(MAX), .ERR_CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .smp_valid(smp_valid), .smp_ready(rdy),
        .smp_in(smp_in), .smp_out(smp_out),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(ecnt), .cover_mask(cmask),
`ifdef TT_CHK_ERRMASK_EN
        .err_mask(em),
`endif
        .first_err_vld(fev), .first_err_idx(fidx)
    );

    truth_table_checker #(
        .N_IN(2), .EXP_TT(4'b0110), .MAX_SMP(MAX), .ERR_CNT_W(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .smp_valid(smp_valid), .smp_ready(rdy2),
        .smp_in(smp_in), .smp_out(smp_out),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(ecnt2), .cover_mask(cmask2),
`ifdef TT_CHK_ERRMASK_EN
        .err_mask(em2),
`endif
        .first_err_vld(fev2), .first_err_idx(fidx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: run state as 0=idle 1=running 2=finished.
    int m_st;
    bit m_seen [4];
    bit m_em   [4];
    int m_errs;
    int m_nsmp;
    bit m_fv;
    int m_fi;
    bit m_pass;

    function automatic int exp_f(input int i);
        return (TT >> i) & 1;
    endfunction

    function automatic int seen_mask();
        int r = 0;
        for (int k = 0; k < 4; k++) if (m_seen[k]) r += (1 << k);
        return r;
    endfunction

    function automatic int em_mask();
        int r = 0;
        for (int k = 0; k < 4; k++) if (m_em[k]) r += (1 << k);
        return r;
    endfunction

    function automatic bit all_seen();
        return m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            m_seen[k] = 0;
            m_em[k]   = 0;
        end
        m_errs = 0;
        m_nsmp = 0;
        m_fv   = 0;
        m_fi   = 0;
        m_pass = 0;
    endtask

    task automatic model_edge(input bit s, input bit v,
                              input int i, input int o);
        if (m_st == 1 && v) begin
            m_nsmp++;
            m_seen[i] = 1;
            if (o != exp_f(i)) begin
                m_errs++;
                m_em[i] = 1;
                if (!m_fv) begin
                    m_fv = 1;
                    m_fi = i;
                end
            end
            if (all_seen() || m_nsmp == MAX) begin
                m_st   = 2;
                m_pass = (m_errs == 0) && all_seen();
            end
        end else if (s && m_st != 1) begin
            model_clear();
            m_st = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string t);
        chk({t, ".busy"},  32'(busy),  32'(m_st == 1));
        chk({t, ".done"},  32'(done),  32'(m_st == 2));
        chk({t, ".ready"}, 32'(rdy),   32'(m_st == 1));
        chk({t, ".pass"},  32'(pass),  32'(m_pass));
        chk({t, ".ecnt"},  32'(ecnt),  (m_errs > 255) ? 255 : m_errs);
        chk({t, ".cmask"}, 32'(cmask), seen_mask());
        chk({t, ".fev"},   32'(fev),   32'(m_fv));
        chk({t, ".fidx"},  32'(fidx),  m_fi);
        chk({t, ".ecnt2"}, 32'(ecnt2), (m_errs > 3) ? 3 : m_errs);
        chk({t, ".done2"}, 32'(done2), 32'(m_st == 2));
`ifdef TT_CHK_ERRMASK_EN
        chk({t, ".emask"}, 32'(em),    em_mask());
`endif
    endtask

    task automatic step(input string t, input bit s, input bit v,
                        input int i, input int o);
        start     = s;
        smp_valid = v;
        smp_in    = 2'(i);
        smp_out   = o[0];
        @(posedge clk);
        model_edge(s, v, i, o);
        #1;
        check_all(t);
        start     = 1'b0;
        smp_valid = 1'b0;
    endtask

    task automatic do_reset(input string t);
        rst_n = 1'b0;
        #2;
        m_st = 0;
        model_clear();
        check_all(t);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        start     = 1'b0;
        smp_valid = 1'b0;
        smp_in    = 2'd0;
        smp_out   = 1'b0;
        m_st      = 0;
        model_clear();
        do_reset("reset");

        // Samples while idle must be ignored.
        step("idle", 0, 1, 3, 1);
        step("idle", 0, 1, 1, 0);

        // Exhaustive correct XOR run.
        step("xor.start", 1, 0, 0, 0);
        step("xor", 0, 1, 0, 0);
        step("xor", 0, 1, 1, 1);
        step("xor", 0, 1, 2, 1);
        step("xor.last", 0, 1, 3, 0);
        step("xor.hold", 0, 1, 3, 1);

        // Two faulty responses; first one at index 1.
        step("fault.start", 1, 0, 0, 0);
        step("fault", 0, 1, 0, 0);
        step("fault", 0, 1, 1, 0);
        step("fault", 0, 1, 2, 1);
        step("fault.last", 0, 1, 3, 1);

        // Sample-limit completion with poor coverage.
        step("limit.start", 1, 0, 0, 0);
        for (int k = 0; k < 16; k++) step("limit", 0, 1, 0, 0);
        step("limit.hold", 0, 0, 0, 0);

        // Reset in the middle of a run, then a normal run.
        step("mid.start", 1, 0, 0, 0);
        step("mid", 0, 1, 1, 0);
        step("mid", 0, 1, 2, 1);
        do_reset("mid.reset");
        step("mid.idle", 0, 1, 3, 0);
        step("mid.restart", 1, 0, 0, 0);
        step("mid.run", 0, 1, 3, 0);
        step("mid.run", 0, 1, 2, 1);
        step("mid.run", 0, 1, 1, 1);
        step("mid.run", 0, 1, 0, 0);

        // Saturation, start ignored in RUN, restart from DONE.
        step("sat.start", 1, 0, 0, 0);
        step("sat", 0, 1, 0, 1);
        step("sat.st", 1, 1, 0, 1);
        step("sat.st", 1, 0, 0, 1);
        step("sat", 0, 1, 0, 1);
        step("sat.st", 1, 1, 0, 1);
        step("sat", 0, 1, 0, 1);
        step("sat", 0, 1, 0, 1);
        for (int k = 0; k < 10; k++) step("sat.fill", 0, 1, 0, 0);
        step("sat.restart", 1, 0, 0, 0);
        step("sat.run", 0, 1, 2, 1);

        // Randomized traffic with occasional start and reset.
        for (int k = 0; k < 400; k++) begin
            int i;
            int o;
            bit s;
            bit v;
            i = $urandom_range(0, 3);
            o = exp_f(i) ^ int'($urandom_range(0, 5) == 0);
            s = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 79) == 0) do_reset("rnd.reset");
            else step("rnd", s, v, i, o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
